cnn_frame_sequencer: RTL and testbench

Controller that sequences one MNIST frame through the CNN chip core. It buffers a 784-pixel frame from a gappy upstream valid/ready stream, then clears the chip and streams the pixels gaplessly, one per cycle, because the chip has no input-valid. It then waits for the chip's result strobe, with a timeout, and returns the class through a valid/ready result port.

---
 rtl/cnn_frame_sequencer_pkg.sv | 8 +
 rtl/cnn_frame_sequencer_if.sv | 22 ++
 rtl/cnn_frame_sequencer_buf.sv | 29 ++
 rtl/cnn_frame_sequencer.sv | 152 +++++++++++++++
 tb/tb_cnn_frame_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_frame_sequencer_pkg.sv
// cnn_pkg: shared state type and frame/class constants for the CNN frame sequencer.
package cnn_pkg;
    localparam int FRAME_PIXELS = 784;
    localparam int CLASS_BITS = 4;
    localparam logic [CLASS_BITS-1:0] CLASS_TIMEOUT = 4'hF;

    typedef enum logic [2:0] {IDLE, LOAD, CLEAR, STREAM, WAIT, RESULT} state_e;
endpackage

// File: rtl/cnn_frame_sequencer_if.sv
// cnn_frame_sequencer_if: upstream pixel stream and downstream result handshake of the frame sequencer.
interface cnn_frame_sequencer_if #(parameter int PIX_BITS = 8);
    import cnn_pkg::*;

    logic                  s_pix_valid;
    logic [PIX_BITS-1:0]   s_pix_data;
    logic                  s_pix_ready;
    logic                  res_valid;
    logic                  res_ready;
    logic [CLASS_BITS-1:0] res_class;
    logic                  res_timeout;

    modport master (
        output s_pix_valid, s_pix_data, res_ready,
        input  s_pix_ready, res_valid, res_class, res_timeout
    );

    modport slave (
        input  s_pix_valid, s_pix_data, res_ready,
        output s_pix_ready, res_valid, res_class, res_timeout
    );
endinterface

// File: rtl/cnn_frame_sequencer_buf.sv
// cnn_frame_buf: frame RAM, synchronous write port and 1-cycle registered read whose output clears when not reading.
module cnn_frame_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 784,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    // The read register doubles as the chip data output, so it idles at zero.
    always_ff @(posedge clk) begin
        rdata_q <= (!rst_n || !re_i) ? '0 : mem[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer: buffers one frame from a gappy stream, clears the CNN core,
// replays the frame gaplessly and returns the core's class (or a timeout) over a handshake.
module cnn_frame_sequencer #(
    parameter int PIX_BITS       = 8,
    parameter int FRAME_PIXELS   = cnn_pkg::FRAME_PIXELS,
    parameter int CLR_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_i,
    input  logic                           abort_i,
    cnn_frame_sequencer_if.slave           bus,
    output logic                           cnn_rst_n_o,
    output logic [PIX_BITS-1:0]            cnn_data_in_o,
    input  logic                           cnn_valid_i,
    input  logic [cnn_pkg::CLASS_BITS-1:0] cnn_decision_i,
    output logic                           busy_o,
    output logic [15:0]                    frame_cnt_o
);
    import cnn_pkg::*;

    localparam int AW = $clog2(FRAME_PIXELS);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int CW = $clog2(CLR_CYCLES + 1);
    localparam logic [AW-1:0] LAST_WR  = AW'(FRAME_PIXELS - 1);
    localparam logic [AW-1:0] RD_END   = AW'(FRAME_PIXELS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);

    state_e                state_q;
    logic [AW-1:0]         wr_addr_q;
    logic [AW-1:0]         rd_addr_q;
    logic [CW-1:0]         clr_cnt_q;
    logic [TW-1:0]         tmo_cnt_q;
    logic                  s_pix_ready_q;
    logic                  cnn_rst_n_q;
    logic                  res_valid_q;
    logic                  res_timeout_q;
    logic                  busy_q;
    logic [CLASS_BITS-1:0] res_class_q;
    logic [15:0]           frame_cnt_q;
    logic                  wr_en_d;
    logic                  rd_en_d;

    assign wr_en_d = bus.s_pix_valid && s_pix_ready_q;
    // rd_addr_q runs one ahead of the pixel on cnn_data_in_o; reads stop once it passes the frame.
    assign rd_en_d = !abort_i && ((state_q == CLEAR && clr_cnt_q == CLR_LAST) ||
                                  (state_q == STREAM && rd_addr_q != RD_END));

    cnn_frame_buf #(
        .WIDTH (PIX_BITS),
        .DEPTH (FRAME_PIXELS),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_en_d),
        .waddr_i (wr_addr_q),
        .wdata_i (bus.s_pix_data),
        .re_i    (rd_en_d),
        .raddr_i (rd_addr_q),
        .rdata_o (cnn_data_in_o)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || abort_i) begin
            state_q       <= IDLE;
            s_pix_ready_q <= 1'b0;
            cnn_rst_n_q   <= rst_n;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            clr_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            if (!rst_n) begin
                res_class_q   <= '0;
                res_timeout_q <= 1'b0;
                frame_cnt_q   <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    cnn_rst_n_q <= 1'b1;
                    if (start_i) begin
                        state_q       <= LOAD;
                        wr_addr_q     <= '0;
                        s_pix_ready_q <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                LOAD: begin
                    if (wr_en_d) begin
                        wr_addr_q <= wr_addr_q + AW'(1);
                        if (wr_addr_q == LAST_WR) begin
                            state_q       <= CLEAR;
                            s_pix_ready_q <= 1'b0;
                            cnn_rst_n_q   <= 1'b0;
                            clr_cnt_q     <= '0;
                            rd_addr_q     <= '0;
                        end
                    end
                end
                CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + CW'(1);
                    if (clr_cnt_q == CLR_LAST) begin
                        state_q     <= STREAM;
                        cnn_rst_n_q <= 1'b1;
                        rd_addr_q   <= rd_addr_q + AW'(1);
                    end
                end
                STREAM: begin
                    if (rd_addr_q == RD_END) begin
                        state_q   <= WAIT;
                        tmo_cnt_q <= '0;
                    end else begin
                        rd_addr_q <= rd_addr_q + AW'(1);
                    end
                end
                WAIT: begin
                    // A strobe on the final timeout cycle still reports the real class.
                    if (cnn_valid_i || tmo_cnt_q == TMO_LAST) begin
                        state_q       <= RESULT;
                        res_valid_q   <= 1'b1;
                        res_class_q   <= cnn_valid_i ? cnn_decision_i : CLASS_TIMEOUT;
                        res_timeout_q <= !cnn_valid_i;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
                    end
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.s_pix_ready = s_pix_ready_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_class   = res_class_q;
    assign bus.res_timeout = res_timeout_q;
    assign cnn_rst_n_o     = cnn_rst_n_q;
    assign busy_o          = busy_q;
    assign frame_cnt_o     = frame_cnt_q;
endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// tb_cnn_frame_sequencer: frame scenario table, random frames and abort/reset/wrap sequences
// checked against a frame-level model of the pixel stream, chip timing and result handshake.
module tb_cnn_frame_sequencer;
    localparam int FP  = 784;
    localparam int TMO = 4096;

    typedef struct {
        int         gap;
        bit         ramp;
        int         delay;
        logic [3:0] dec;
        int         hold;
        bit         abort_hs;
        logic [3:0] exp_class;
        bit         exp_tmo;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       cnn_valid = 1'b0;
    logic [3:0] cnn_decision = 4'd0;
    logic       cnn_rst_n;
    logic       busy;
    logic [7:0] cnn_data_in;
    logic [15:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    logic [7:0]  exp_pix[$];
    logic [7:0]  got[$];
    logic [15:0] exp_cnt = 16'd0;
    int          low_run, last_low, post, res_post, chip_delay;
    bit          streaming, waiting, noise;
    logic [3:0]  chip_dec;
    vec_t        tbl[6];

    cnn_frame_sequencer_if #(.PIX_BITS(8)) bus();

    cnn_frame_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start),
        .abort_i        (abort),
        .bus            (bus),
        .cnn_rst_n_o    (cnn_rst_n),
        .cnn_data_in_o  (cnn_data_in),
        .cnn_valid_i    (cnn_valid),
        .cnn_decision_i (cnn_decision),
        .busy_o         (busy),
        .frame_cnt_o    (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic mon_clear();
        streaming = 0;
        waiting   = 0;
        low_run   = 0;
        res_post  = -1;
        got.delete();
    endtask

    // One clock: observe outputs just after the edge, then drive the chip model for this cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (!cnn_rst_n && busy) low_run++;
        else if (cnn_rst_n && low_run > 0) begin
            last_low  = low_run;
            low_run   = 0;
            streaming = 1;
            got.delete();
        end
        if (streaming) begin
            got.push_back(cnn_data_in);
            if (got.size() == FP) begin
                streaming = 0;
                waiting   = 1;
                post      = 0;
            end
        end else if (waiting) begin
            post++;
            if (bus.res_valid) begin
                res_post = post;
                waiting  = 0;
            end
        end
        cnn_valid    = 1'b0;
        cnn_decision = 4'($urandom);
        if (noise && (streaming || low_run > 0)) cnn_valid = ($urandom_range(0, 7) == 0);
        else if (waiting && post == chip_delay) begin
            cnn_valid    = 1'b1;
            cnn_decision = chip_dec;
        end
    endtask

    task automatic load(int gap_pct, bit ramp, int n);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 20000) begin
            bit hs;
            logic [7:0] d;
            d = ramp ? 8'(i) : 8'($urandom);
            bus.s_pix_valid = ($urandom_range(0, 99) >= gap_pct);
            bus.s_pix_data  = d;
            hs = bus.s_pix_valid && bus.s_pix_ready;
            cyc();
            if (hs) begin
                exp_pix.push_back(d);
                i++;
            end
            guard++;
        end
        bus.s_pix_valid = 1'b0;
        if (i < n) check("load_stalled", i, n);
    endtask

    task automatic wait_res(int limit);
        int n = 0;
        while (!bus.res_valid && n < limit) begin
            cyc();
            n++;
        end
        if (!bus.res_valid) check("result_never_came", 0, 1);
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_s_pix_ready"}, bus.s_pix_ready, 0);
        check({tag, "_cnn_rst_n"}, cnn_rst_n, 0);
        check({tag, "_cnn_data_in"}, cnn_data_in, 0);
        check({tag, "_res_valid"}, bus.res_valid, 0);
        check({tag, "_res_class"}, bus.res_class, 0);
        check({tag, "_res_timeout"}, bus.res_timeout, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    task automatic run_frame(vec_t v);
        int exp_lat;
        int mism = 0;
        int unstable = 0;
        exp_pix.delete();
        mon_clear();
        chip_delay = v.delay;
        chip_dec   = v.dec;
        noise      = 1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        load(v.gap, v.ramp, FP);
        bus.s_pix_valid = 1'b1;
        bus.s_pix_data  = 8'hAA;
        check("ready_after_last_pixel", bus.s_pix_ready, 0);
        cyc();
        bus.s_pix_valid = 1'b0;
        wait_res(FP + TMO + 50);
        check("clear_cycles", last_low, 2);
        check("stream_len", got.size(), FP);
        for (int i = 0; i < FP; i++) if (got[i] !== exp_pix[i]) mism++;
        check("stream_pixels_mismatched", mism, 0);
        exp_lat = (v.delay >= 1 && v.delay <= TMO) ? v.delay + 1 : TMO + 1;
        check("result_latency", res_post, exp_lat);
        check("res_class", bus.res_class, v.exp_class);
        check("res_timeout", bus.res_timeout, v.exp_tmo);
        bus.res_ready = 1'b0;
        for (int h = 0; h < v.hold; h++) begin
            start = (h == v.hold / 2);
            cyc();
            start = 1'b0;
            if (!bus.res_valid || bus.res_class != v.exp_class || bus.res_timeout != v.exp_tmo) unstable++;
        end
        if (v.hold > 0) check("result_hold_unstable", unstable, 0);
        bus.res_ready = 1'b1;
        abort = v.abort_hs;
        cyc();
        bus.res_ready = 1'b0;
        abort = 1'b0;
        if (!v.abort_hs) exp_cnt++;
        check("res_valid_after_hs", bus.res_valid, 0);
        check("frame_cnt", frame_cnt, exp_cnt);
        check("idle_after_hs", busy, 0);
        cyc();
        check("no_queued_start", busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t r;
        int guard;
        bus.s_pix_valid = 1'b0;
        bus.s_pix_data  = 8'd0;
        bus.res_ready   = 1'b0;
        chip_delay = -1;
        chip_dec   = 4'd0;
        noise      = 0;
        mon_clear();

        tbl[0] = '{0,  1, 50,  4'd2, 0,  0, 4'd2, 0};
        tbl[1] = '{70, 0, 10,  4'd7, 20, 0, 4'd7, 0};
        tbl[2] = '{0,  0, -1,  4'd0, 3,  0, 4'hF, 1};
        tbl[3] = '{0,  0, TMO, 4'd5, 1,  0, 4'd5, 0};
        tbl[4] = '{20, 0, 1,   4'd9, 0,  0, 4'd9, 0};
        tbl[5] = '{0,  1, 20,  4'd3, 2,  1, 4'd3, 0};

        repeat (3) cyc();
        check_reset_vals("reset");
        rst_n = 1'b1;
        cyc();
        check("cnn_rst_n_rise", cnn_rst_n, 1);

        start = 1'b1;
        abort = 1'b1;
        cyc();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", busy, 0);
        check("start_abort_ready", bus.s_pix_ready, 0);

        for (int t = 0; t < 6; t++) run_frame(tbl[t]);

        for (int t = 0; t < 2; t++) begin
            r.gap       = $urandom_range(0, 50);
            r.ramp      = 0;
            r.delay     = $urandom_range(1, 200);
            r.dec       = 4'($urandom_range(0, 9));
            r.hold      = $urandom_range(0, 5);
            r.abort_hs  = 0;
            r.exp_class = r.dec;
            r.exp_tmo   = 0;
            run_frame(r);
        end

        exp_pix.delete();
        mon_clear();
        chip_delay = -1;
        noise      = 0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        load(0, 1, FP);
        guard = 0;
        while (got.size() != 401 && guard < 100 + FP) begin
            cyc();
            guard++;
        end
        check("abort_reached_pixel_400", got.size(), 401);
        check("pixel_400_value", got[400], 144);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        mon_clear();
        check("abort_busy", busy, 0);
        check("abort_data", cnn_data_in, 0);
        check("abort_cnn_rst_n", cnn_rst_n, 1);
        check("abort_ready", bus.s_pix_ready, 0);
        check("abort_res_valid", bus.res_valid, 0);
        check("abort_frame_cnt", frame_cnt, exp_cnt);
        cyc();
        check("abort_data_stays_0", cnn_data_in, 0);

        start = 1'b1;
        cyc();
        start = 1'b0;
        load(0, 0, 100);
        check("ready_mid_load", bus.s_pix_ready, 1);
        rst_n = 1'b0;
        cyc();
        check_reset_vals("midreset");
        rst_n = 1'b1;
        exp_cnt = 16'd0;
        cyc();
        mon_clear();
        check("midreset_cnn_rst_n_rise", cnn_rst_n, 1);

        force dut.frame_cnt_q = 16'hFFFF;
        cyc();
        release dut.frame_cnt_q;
        cyc();
        exp_cnt = 16'hFFFF;
        check("frame_cnt_preset", frame_cnt, 16'hFFFF);
        run_frame(tbl[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
